// File: rtl/vga_mem_arbiter_pkg.sv
// Shared types and default sizes for the framebuffer arbiter.
// Used by vga_mem_arbiter and arb_wbuf.
package vga_mem_pkg;

  localparam int VGA_ADDR_W    = 17;
  localparam int VGA_DATA_W    = 8;
  localparam int VGA_MEM_WORDS = 76800;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_DONE
  } arb_state_e;

  typedef struct packed {
    logic [VGA_ADDR_W-1:0] addr;
    logic [VGA_DATA_W-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/vga_mem_arbiter_wbuf.sv
// arb_wbuf: small synchronous FIFO of pending framebuffer writes.
// Flush empties it in one cycle and overrides push/pop.
module arb_wbuf
  import vga_mem_pkg::*;
#(
  parameter int AW    = VGA_ADDR_W,
  parameter int DW    = VGA_DATA_W,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          n_reset,
  input  logic          push_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [AW-1:0] raddr_o,
  output logic [DW-1:0] rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_nxt_o
);

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  ent_t          mem_q [DEPTH];
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wp_d = wp_q + 1'b1;
      if (do_pop)  rp_d = rp_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload storage needs no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) begin
      mem_q[wp_q] <= '{addr: waddr_i, data: wdata_i};
    end
  end

  assign raddr_o     = mem_q[rp_q].addr;
  assign rdata_o     = mem_q[rp_q].data;
  assign count_nxt_o = cnt_d;

endmodule

// File: rtl/vga_mem_arbiter.sv
// vga_mem_arbiter: single-port framebuffer arbiter (read > clear > write).
// Define ARB_STATS_EN to add the 16-bit saturating stall_cnt output.
module vga_mem_arbiter
  import vga_mem_pkg::*;
#(
  parameter int ADDR_W     = VGA_ADDR_W,
  parameter int DATA_W     = VGA_DATA_W,
  parameter int MEM_WORDS  = VGA_MEM_WORDS,
  parameter int WBUF_DEPTH = 4,
  parameter int RD_LAT     = 1,
  parameter int CLEAR_VAL  = 0
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic              mode_sel,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clear_req,
  output logic              clear_busy,
  output logic              clear_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef ARB_STATS_EN
  output logic [15:0]       stall_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = $clog2(WBUF_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(MEM_WORDS - 1);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [RD_LAT:0]   vld_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              wr_ready_q, wr_ready_d;

  logic              clr_start;
  logic              g_rd, g_clr, pop, push;
  logic              wb_full, wb_empty;
  logic [CW-1:0]     wb_cnt_nxt;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;

  assign clr_start = (state_q == S_IDLE) & clear_req;
  assign g_rd  = rd_req;
  assign g_clr = (state_q == S_CLEAR) & ~rd_req;
  assign pop   = (state_q == S_IDLE) & ~clear_req
               & ~rd_req & ~wb_empty;
  assign push  = wr_req & wr_ready_q & ~wb_full;

  arb_wbuf #(
    .AW    (ADDR_W),
    .DW    (DATA_W),
    .DEPTH (WBUF_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .n_reset     (n_reset),
    .push_i      (push),
    .waddr_i     (wr_addr),
    .wdata_i     (wr_data),
    .pop_i       (pop),
    .flush_i     (clr_start),
    .raddr_o     (wb_addr),
    .rdata_o     (wb_data),
    .full_o      (wb_full),
    .empty_o     (wb_empty),
    .count_nxt_o (wb_cnt_nxt)
  );

  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d = S_CLEAR;
          sweep_d = '0;
        end
      end
      S_CLEAR: begin
        if (g_clr) begin
          if (sweep_q == LAST) begin
            sweep_d = '0;
            state_d = S_DONE;
          end else begin
            sweep_d = sweep_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Grant terms are mutually exclusive by construction.
  always_comb begin
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    unique case (1'b1)
      g_rd: begin
        mem_addr_d = rd_addr;
      end
      g_clr: begin
        mem_addr_d  = sweep_q;
        mem_we_d    = 1'b1;
        mem_wdata_d = DATA_W'(CLEAR_VAL);
      end
      pop: begin
        mem_addr_d  = wb_addr;
        mem_we_d    = 1'b1;
        mem_wdata_d = wb_data;
      end
      default: ;
    endcase
  end

  assign wr_ready_d = mode_sel
                    & (wb_cnt_nxt != CW'(WBUF_DEPTH))
                    & (state_d == S_IDLE);

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q     <= S_IDLE;
      sweep_q     <= '0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      vld_q       <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      wr_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sweep_q     <= sweep_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      vld_q       <= {vld_q[RD_LAT-1:0], rd_req};
      rd_valid_q  <= vld_q[RD_LAT];
      wr_ready_q  <= wr_ready_d;
      if (vld_q[RD_LAT]) rd_data_q <= mem_rdata;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stall_q <= '0;
    end else if (clr_start) begin
      stall_q <= '0;
    end else if (g_rd && !wb_empty && stall_q != 16'hFFFF) begin
      stall_q <= stall_q + 1'b1;
    end
  end

  assign stall_cnt = stall_q;
`endif

  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;
  assign wr_ready   = wr_ready_q;
  assign clear_busy = (state_q == S_CLEAR);
  assign clear_done = (state_q == S_DONE);

endmodule

// File: tb/tb_vga_mem_arbiter.sv
// Directed bench for vga_mem_arbiter: vector table plus
// hand sequences for FIFO fill, clear sweep, flush and reset abort.
module tb_vga_mem_arbiter;

  localparam int AW = 17;
  localparam int DW = 8;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          mode_sel = 1'b0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          clear_req = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          rd_valid, wr_ready, clear_busy, clear_done, mem_we;
  logic [DW-1:0] rd_data, mem_wdata;
  logic [AW-1:0] mem_addr;
`ifdef ARB_STATS_EN
  logic [15:0]   stall_cnt;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  vga_mem_arbiter #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .MEM_WORDS  (MW),
    .WBUF_DEPTH (4),
    .RD_LAT     (1),
    .CLEAR_VAL  (0)
  ) dut (
    .clk        (clk),
    .n_reset    (n_reset),
    .mode_sel   (mode_sel),
    .rd_req     (rd_req),
    .rd_addr    (rd_addr),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .wr_req     (wr_req),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .clear_req  (clear_req),
    .clear_busy (clear_busy),
    .clear_done (clear_done),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
`ifdef ARB_STATS_EN
    .stall_cnt  (stall_cnt),
`endif
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    logic          mode;
    logic          rd;
    logic [AW-1:0] ra;
    logic          wr;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [DW-1:0] rdat;
    logic [AW-1:0] e_addr;
    logic          e_we;
    logic [DW-1:0] e_wd;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_wrdy;
  } vec_t;

  vec_t tbl [18];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".mem_addr"},   32'(mem_addr),   0);
    chk({tag, ".mem_we"},     32'(mem_we),     0);
    chk({tag, ".mem_wdata"},  32'(mem_wdata),  0);
    chk({tag, ".rd_valid"},   32'(rd_valid),   0);
    chk({tag, ".rd_data"},    32'(rd_data),    0);
    chk({tag, ".wr_ready"},   32'(wr_ready),   0);
    chk({tag, ".clear_busy"}, 32'(clear_busy), 0);
    chk({tag, ".clear_done"}, 32'(clear_done), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout");
    $fatal(1, "bench timed out");
  end

  initial begin
    int nw, nd;
    logic found;

    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0,         0, 0, 0, 0, 0, 1};
    tbl[1]  = '{1, 1, 'h10, 0, 0, 0, 'hA5,   'h10, 0, 0, 0, 0, 1};
    tbl[2]  = '{1, 0, 0, 0, 0, 0, 'hA5,      'h10, 0, 0, 0, 0, 1};
    tbl[3]  = '{1, 0, 0, 0, 0, 0, 'hA5,      'h10, 0, 0, 1, 'hA5, 1};
    tbl[4]  = '{1, 0, 0, 1, 'h123, 'h3C, 0,  'h10, 0, 0, 0, 'hA5, 1};
    tbl[5]  = '{1, 0, 0, 0, 0, 0, 0,         'h123, 1, 'h3C, 0, 'hA5, 1};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0,         'h123, 0, 'h3C, 0, 'hA5, 0};
    tbl[7]  = '{0, 0, 0, 1, 'h55, 'h77, 0,   'h123, 0, 'h3C, 0, 'hA5, 0};
    tbl[8]  = '{0, 0, 0, 0, 0, 0, 0,         'h123, 0, 'h3C, 0, 'hA5, 0};
    tbl[9]  = '{1, 1, 'h1FFFF, 0, 0, 0, 'h5A, 'h1FFFF, 0, 'h3C, 0, 'hA5, 1};
    tbl[10] = '{1, 1, 'h1, 0, 0, 0, 'h5A,    'h1, 0, 'h3C, 0, 'hA5, 1};
    tbl[11] = '{1, 0, 0, 0, 0, 0, 'h5A,      'h1, 0, 'h3C, 1, 'h5A, 1};
    tbl[12] = '{1, 0, 0, 0, 0, 0, 'hC3,      'h1, 0, 'h3C, 1, 'hC3, 1};
    tbl[13] = '{1, 0, 0, 0, 0, 0, 'hC3,      'h1, 0, 'h3C, 0, 'hC3, 1};
    tbl[14] = '{1, 0, 0, 1, 'h2, 'h22, 0,    'h1, 0, 'h3C, 0, 'hC3, 1};
    tbl[15] = '{1, 0, 0, 1, 'h3, 'h33, 0,    'h2, 1, 'h22, 0, 'hC3, 1};
    tbl[16] = '{1, 0, 0, 0, 0, 0, 0,         'h3, 1, 'h33, 0, 'hC3, 1};
    tbl[17] = '{1, 0, 0, 0, 0, 0, 0,         'h3, 0, 'h33, 0, 'hC3, 1};

    // reset and release
    step(); step(); step();
    chk_reset("in_rst");
    n_reset = 1'b1;
    step();
    chk_reset("post_rst");

    // single-cycle vectors
    for (int i = 0; i < 18; i++) begin
      mode_sel  = tbl[i].mode;
      rd_req    = tbl[i].rd;
      rd_addr   = tbl[i].ra;
      wr_req    = tbl[i].wr;
      wr_addr   = tbl[i].wa;
      wr_data   = tbl[i].wd;
      mem_rdata = tbl[i].rdat;
      step();
      chk($sformatf("v%0d.mem_addr", i), 32'(mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d.mem_we", i), 32'(mem_we), 32'(tbl[i].e_we));
      chk($sformatf("v%0d.mem_wdata", i), 32'(mem_wdata), 32'(tbl[i].e_wd));
      chk($sformatf("v%0d.rd_valid", i), 32'(rd_valid), 32'(tbl[i].e_rv));
      chk($sformatf("v%0d.rd_data", i), 32'(rd_data), 32'(tbl[i].e_rd));
      chk($sformatf("v%0d.wr_ready", i), 32'(wr_ready), 32'(tbl[i].e_wrdy));
    end
    wr_req = 1'b0;
    mem_rdata = '0;

    // fill FIFO under continuous reads, then drain in order
    mode_sel = 1'b1;
    rd_req = 1'b1;
    rd_addr = 17'h00100;
    for (int i = 1; i <= 4; i++) begin
      wr_req = 1'b1;
      wr_addr = AW'(i);
      wr_data = DW'(i * 17);
      step();
      chk($sformatf("fill%0d.wr_ready", i), 32'(wr_ready), (i < 4) ? 1 : 0);
      chk($sformatf("fill%0d.mem_we", i), 32'(mem_we), 0);
    end
    wr_req = 1'b0;
    step();
    chk("fill.hold_we", 32'(mem_we), 0);
    chk("fill.hold_rdy", 32'(wr_ready), 0);
    rd_req = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk($sformatf("drain%0d.we", i), 32'(mem_we), 1);
      chk($sformatf("drain%0d.addr", i), 32'(mem_addr), i);
      chk($sformatf("drain%0d.data", i), 32'(mem_wdata), i * 17);
    end
    step();
    chk("drain.end_we", 32'(mem_we), 0);
    chk("drain.end_rdy", 32'(wr_ready), 1);

    // clear sweep with reads on alternate cycles
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("clr.busy0", 32'(clear_busy), 1);
    chk("clr.rdy0", 32'(wr_ready), 0);
    nw = 0;
    nd = 0;
    rd_addr = 17'h00200;
    for (int c = 0; c < 40 && nd == 0; c++) begin
      rd_req = c[0];
      step();
      if (mem_we) begin
        chk("clr.addr", 32'(mem_addr), nw);
        chk("clr.data", 32'(mem_wdata), 0);
        nw++;
      end
      if (clear_done) begin
        nd++;
        chk("clr.busy_done", 32'(clear_busy), 0);
      end else begin
        chk("clr.busy", 32'(clear_busy), 1);
      end
      chk("clr.rdy", 32'(wr_ready), 0);
    end
    rd_req = 1'b0;
    chk("clr.writes", nw, MW);
    chk("clr.done_seen", nd, 1);
    step();
    chk("clr.done_pulse", 32'(clear_done), 0);
    chk("clr.busy_end", 32'(clear_busy), 0);
    chk("clr.rdy_back", 32'(wr_ready), 1);
    step();
    chk("clr.fifo_empty", 32'(mem_we), 0);

    // clear while two entries are buffered discards them
    rd_req = 1'b1;
    wr_req = 1'b1;
    wr_addr = 17'h00040;
    wr_data = 8'hEE;
    step();
    wr_addr = 17'h00041;
    step();
    wr_req = 1'b0;
    chk("flush.rdy_pre", 32'(wr_ready), 1);
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    rd_req = 1'b0;
    nd = 0;
    for (int c = 0; c < 30 && nd == 0; c++) begin
      step();
      if (mem_we) begin
        chk("flush.data", 32'(mem_wdata), 0);
        chk("flush.addr_lt8", 32'(mem_addr < AW'(MW)), 1);
      end
      chk("flush.rdy", 32'(wr_ready), 0);
      if (clear_done) nd++;
    end
    chk("flush.done_seen", nd, 1);
    step();
    chk("flush.rdy_idle", 32'(wr_ready), 1);
    chk("flush.no_pop1", 32'(mem_we), 0);
    step();
    chk("flush.no_pop2", 32'(mem_we), 0);

    // reset during the sweep at address 3
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      step();
      if (mem_we && mem_addr == 17'h3) found = 1'b1;
    end
    chk("abort.reached3", 32'(found), 1);
    n_reset = 1'b0;
    #1;
    chk_reset("abort");
    step();
    step();
    n_reset = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step();
      if (c == 0) chk("abort.rdy", 32'(wr_ready), 1);
      chk("abort.no_done", 32'(clear_done), 0);
      chk("abort.no_busy", 32'(clear_busy), 0);
      chk("abort.no_we", 32'(mem_we), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_mem_arbiter.md
Name: vga_mem_arbiter

Overview:
Arbitrates one single-port framebuffer RAM between three users:
- the VGA pixel fetch path (read),
- the button-driven drawing/write path,
- an internal clear-screen sweeper.

Display reads have absolute priority so video never glitches. Writes are absorbed by a small FIFO and drained in idle cycles. Write acceptance is gated by the debounced write-mode select.

Parameters:
ADDR_W, 17, framebuffer address width
DATA_W, 8, pixel word width
MEM_WORDS, 76800, number of framebuffer words the clear sweep covers (320x240)
WBUF_DEPTH, 4, write-FIFO entries (power of two, >=2)
RD_LAT, 1, RAM read latency in cycles (>=1)
CLEAR_VAL, 0, pixel value written by the clear sweep

Ports:
clk  in  1  system clock
n_reset  in  1  asynchronous, active-low reset
mode_sel  in  1  write mode enabled (from debounced mode toggle)
rd_req  in  1  VGA fetch request, single-cycle strobe per pixel
rd_addr  in  ADDR_W  VGA fetch address
rd_valid  out  1  read data valid strobe
rd_data  out  DATA_W  read data
wr_req  in  1  write request (valid)
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
wr_ready  out  1  write FIFO can accept; transfer = wr_req & wr_ready
clear_req  in  1  start clear-screen sweep (one-cycle pulse)
clear_busy  out  1  sweep in progress
clear_done  out  1  one-cycle pulse after last clear write
mem_addr  out  ADDR_W  RAM address (registered)
mem_we  out  1  RAM write enable (registered)
mem_wdata  out  DATA_W  RAM write data (registered)
mem_rdata  in  DATA_W  RAM read data, valid RD_LAT cycles after address

Behaviour:
- Reset (asynchronous, n_reset=0) forces:
  - all outputs to 0: mem_addr, mem_we, mem_wdata, rd_valid, rd_data, wr_ready, clear_busy, clear_done;
  - FIFO empty, sweep counter 0, FSM in S_IDLE.
- Per-cycle grant priority: read > clear > buffered write. Exactly one RAM operation per cycle at most.
- FSM states:
  - S_IDLE -> S_CLEAR on clear_req.
  - S_CLEAR -> S_DONE when the sweep counter reaches MEM_WORDS-1 and that write is issued.
  - S_DONE -> S_IDLE after 1 cycle; clear_done=1 in S_DONE only.
  - clear_req is ignored outside S_IDLE.
- Read path:
  - rd_req sampled at edge k drives mem_addr=rd_addr, mem_we=0 after edge k.
  - mem_rdata is captured into rd_data with rd_valid=1 exactly RD_LAT+1 cycles after the sampling edge.
  - This uses a shift-register valid pipeline; back-to-back reads are allowed every cycle.
- Clear sweep:
  - In S_CLEAR, each cycle without rd_req writes CLEAR_VAL at the sweep address, then increments the address.
  - Cycles with rd_req pause the sweep (counter holds).
  - clear_busy=1 in S_CLEAR.
- Write FIFO:
  - wr_ready = mode_sel & !full & (state==S_IDLE), registered from the post-update count.
  - On clear start, all buffered entries are discarded and count is set to 0.
  - A push and pop in the same cycle leaves the count unchanged.
  - Pop happens only in S_IDLE when the FIFO is non-empty and rd_req=0; it drives mem_we=1 with the head entry.
- mode_sel falling: wr_ready drops the next cycle. Already-buffered entries still drain.
- Address width: rd_addr/wr_addr are used unmodified. The sweep counter is ADDR_W bits and wraps to 0 at the end of the sweep.
- Reset mid-sweep aborts the sweep; no clear_done is produced.

Optional Feature:
ARB_STATS_EN
- Defined: adds output stall_cnt (16 bits). It increments on each cycle where the FIFO is non-empty and a read wins the grant. It saturates at 0xFFFF and clears on reset and at clear start.
- Undefined: the port and the counter are absent; behaviour is otherwise identical.

Decomposition:
- Package vga_mem_pkg holds:
  - the FSM enum type (S_IDLE, S_CLEAR, S_DONE);
  - the write-entry struct {addr, data};
  - default ADDR_W/DATA_W/MEM_WORDS constants.
- Sub-module arb_wbuf: a synchronous FIFO of write entries with push, pop, flush, full, empty and count; depth WBUF_DEPTH.

Test Plan:
- Reset release, idle inputs -> all outputs 0; wr_ready rises 1 cycle after mode_sel=1.
- RD_LAT=1, rd_req with rd_addr=0x00010 at edge k, mem_rdata=0xA5 -> mem_addr=0x00010 after k; rd_valid=1, rd_data=0xA5 at k+2.
- mode_sel=1, push 4 writes (addr 1..4, data 0x11..0x44) while rd_req=1 continuously -> wr_ready=0 after the 4th push, no mem_we; then rd_req=0 -> 4 consecutive mem_we cycles in order 1..4.
- MEM_WORDS=8, clear_req with rd_req asserted every other cycle -> 8 writes of CLEAR_VAL to addresses 0..7, clear_busy high throughout, one clear_done pulse, FIFO count 0.
- Clear mid-drain: 2 entries buffered, clear_req -> entries never written; wr_ready=0 until S_IDLE.
- n_reset asserted at sweep address 3 -> immediate return to reset values; no clear_done.
